// File: rtl/uart_pkg.sv
// Shared constants for the UART receive controller: register map, bit positions
// and the idle-timeout state encoding.
package uart_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_BAUD   = 2'd2;
    localparam logic [1:0] REG_CTRL   = 2'd3;

    localparam int DATA_PERR  = 8;
    localparam int DATA_VALID = 31;

    localparam int ST_NOT_EMPTY = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_OVERRUN   = 2;
    localparam int ST_PARITY    = 3;
    localparam int ST_TIMEOUT   = 4;

    localparam int CTRL_PAR_EN  = 0;
    localparam int CTRL_PAR_ODD = 1;
    localparam int CTRL_IRQ_RX  = 2;
    localparam int CTRL_IRQ_ERR = 3;
    localparam int CTRL_IRQ_TO  = 4;
    localparam int CTRL_FLUSH   = 8;

    typedef enum logic [1:0] {
        TO_OFF   = 2'd0,
        TO_COUNT = 2'd1,
        TO_FIRED = 2'd2
    } to_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO, 9 bits wide ({parity_err, byte}). Flush beats everything;
// a push into a full FIFO is accepted only when a pop happens in the same cycle.
module uart_rx_fifo #(
    parameter int DEPTH = 16,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          FLUSH,
    input  logic          PUSH,
    input  logic          POP,
    input  logic [8:0]    DIN,
    output logic [8:0]    DOUT,
    output logic          EMPTY,
    output logic          FULL,
    output logic [AW:0]   COUNT
);

    logic [8:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push;
    logic          do_pop;

    assign EMPTY   = (count_q == '0);
    assign FULL    = (count_q == (AW+1)'(DEPTH));
    assign COUNT   = count_q;
    assign DOUT    = mem_q[rd_ptr_q];
    assign do_pop  = POP & ~EMPTY;
    assign do_push = PUSH & (~FULL | do_pop);

    always_ff @(posedge CLK) begin
        if (RESET || FLUSH) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage is not reset; the pointers alone define what is valid.
    always_ff @(posedge CLK) begin
        if (do_push && !FLUSH && !RESET) mem_q[wr_ptr_q] <= DIN;
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: configuration registers, receive FIFO, sticky status,
// idle-timeout detection and a level interrupt behind a 4-word register port.
module uart_rx_ctrl #(
    parameter int          DEPTH        = 16,
    parameter logic [15:0] DEF_BIT_TIME = 16'd434,
    parameter logic [7:0]  TIMEOUT_BITS = 8'd32
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [7:0]  RX_DATA,
    input  logic        RX_EN,
    input  logic        RX_PERR,
    input  logic        RX_IDLE,
    output logic [15:0] BIT_TIME,
    output logic        PARITY_EN,
    output logic        PARITY_ODD,
    input  logic [1:0]  ADDR,
    input  logic        WE,
    input  logic        RE,
    input  logic [31:0] WDATA,
    output logic [31:0] RDATA,
    output logic        IRQ
);
    import uart_pkg::*;

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [8:0]  fifo_dout;
    logic        fifo_empty;
    logic        fifo_full;
    logic [AW:0] fifo_count;

    logic [15:0] bit_time_q;
    logic [4:0]  ctrl_q;
    logic        overrun_q, parity_q, timeout_q;
    logic [31:0] rdata_q;
    logic        irq_q;

    to_state_e   to_state_q, to_state_d;
    logic [15:0] presc_q, presc_d;
    logic [7:0]  bits_q, bits_d;
    logic        to_set;

    logic        rd_data, pop, wr_status, wr_baud, wr_ctrl, flush, kick;
    logic [8:0]  count9;
    logic [7:0]  count_field;
    logic [31:0] rd_mux;
    logic        unused_wdata;

    assign rd_data   = RE & (ADDR == REG_DATA);
    assign pop       = rd_data & ~fifo_empty;
    assign wr_status = WE & (ADDR == REG_STATUS);
    assign wr_baud   = WE & (ADDR == REG_BAUD);
    assign wr_ctrl   = WE & (ADDR == REG_CTRL);
    assign flush     = wr_ctrl & WDATA[CTRL_FLUSH];
    // Any of these restarts the idle measurement.
    assign kick      = RX_EN | pop | ~RX_IDLE | fifo_empty;

    assign unused_wdata = ^WDATA[31:16];

    uart_rx_fifo #(.DEPTH(DEPTH)) u_fifo (
        .CLK   (CLK),
        .RESET (RESET),
        .FLUSH (flush),
        .PUSH  (RX_EN),
        .POP   (pop),
        .DIN   ({RX_PERR, RX_DATA}),
        .DOUT  (fifo_dout),
        .EMPTY (fifo_empty),
        .FULL  (fifo_full),
        .COUNT (fifo_count)
    );

    assign count9      = 9'(fifo_count);
    assign count_field = count9[8] ? 8'hFF : count9[7:0];

    always_comb begin
        rd_mux = '0;
        case (ADDR)
            REG_DATA:   rd_mux = fifo_empty ? 32'd0 : {1'b1, 22'd0, fifo_dout};
            REG_STATUS: rd_mux = {16'd0, count_field, 3'd0, timeout_q, parity_q,
                                  overrun_q, fifo_full, ~fifo_empty};
            REG_BAUD:   rd_mux = {16'd0, bit_time_q};
            REG_CTRL:   rd_mux = {27'd0, ctrl_q};
            default:    rd_mux = '0;
        endcase
    end

    always_comb begin
        to_state_d = to_state_q;
        presc_d    = presc_q;
        bits_d     = bits_q;
        to_set     = 1'b0;
        case (to_state_q)
            TO_OFF: begin
                if (TIMEOUT_BITS != 8'd0 && !kick) to_state_d = TO_COUNT;
            end
            TO_COUNT: begin
                if (kick) begin
                    to_state_d = TO_OFF;
                    presc_d    = '0;
                    bits_d     = '0;
                end else if (presc_q == bit_time_q) begin
                    presc_d = '0;
                    bits_d  = bits_q + 8'd1;
                    if (bits_q + 8'd1 == TIMEOUT_BITS) begin
                        to_set     = 1'b1;
                        to_state_d = TO_FIRED;
                    end
                end else begin
                    presc_d = presc_q + 16'd1;
                end
            end
            TO_FIRED: begin
                if (kick) begin
                    to_state_d = TO_OFF;
                    presc_d    = '0;
                    bits_d     = '0;
                end
            end
            default: to_state_d = TO_OFF;
        endcase
    end

    // A sticky event in the same cycle as its write-1-to-clear wins.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            bit_time_q <= DEF_BIT_TIME;
            ctrl_q     <= '0;
            overrun_q  <= 1'b0;
            parity_q   <= 1'b0;
            timeout_q  <= 1'b0;
            rdata_q    <= '0;
            irq_q      <= 1'b0;
            to_state_q <= TO_OFF;
            presc_q    <= '0;
            bits_q     <= '0;
        end else begin
            if (wr_baud) bit_time_q <= WDATA[15:0];
            if (wr_ctrl) ctrl_q <= WDATA[4:0];
            overrun_q <= (overrun_q & ~(wr_status & WDATA[ST_OVERRUN]))
                       | (RX_EN & fifo_full & ~pop & ~flush);
            parity_q  <= (parity_q & ~(wr_status & WDATA[ST_PARITY])) | (RX_EN & RX_PERR);
            timeout_q <= (timeout_q & ~(wr_status & WDATA[ST_TIMEOUT])) | to_set;
            if (RE) rdata_q <= rd_mux;
            irq_q <= (ctrl_q[CTRL_IRQ_RX] & ~fifo_empty)
                   | (ctrl_q[CTRL_IRQ_ERR] & (overrun_q | parity_q))
                   | (ctrl_q[CTRL_IRQ_TO] & timeout_q);
            to_state_q <= to_state_d;
            presc_q    <= presc_d;
            bits_q     <= bits_d;
        end
    end

    assign BIT_TIME   = bit_time_q;
    assign PARITY_EN  = ctrl_q[CTRL_PAR_EN];
    assign PARITY_ODD = ctrl_q[CTRL_PAR_ODD];
    assign RDATA      = rdata_q;
    assign IRQ        = irq_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: directed register-level scenarios plus randomized traffic
// checked every cycle against a queue-based behavioural model.
module tb_uart_rx_ctrl;
    import uart_pkg::*;

    localparam int          DEPTH   = 16;
    localparam logic [15:0] DEF_BT  = 16'd434;
    localparam logic [7:0]  TB_BITS = 8'd32;

    logic        CLK, RESET;
    logic [7:0]  RX_DATA;
    logic        RX_EN, RX_PERR, RX_IDLE;
    logic [15:0] BIT_TIME;
    logic        PARITY_EN, PARITY_ODD;
    logic [1:0]  ADDR;
    logic        WE, RE;
    logic [31:0] WDATA, RDATA;
    logic        IRQ;

    uart_rx_ctrl #(.DEPTH(DEPTH), .DEF_BIT_TIME(DEF_BT), .TIMEOUT_BITS(TB_BITS)) dut (
        .CLK(CLK), .RESET(RESET), .RX_DATA(RX_DATA), .RX_EN(RX_EN), .RX_PERR(RX_PERR),
        .RX_IDLE(RX_IDLE), .BIT_TIME(BIT_TIME), .PARITY_EN(PARITY_EN),
        .PARITY_ODD(PARITY_ODD), .ADDR(ADDR), .WE(WE), .RE(RE), .WDATA(WDATA),
        .RDATA(RDATA), .IRQ(IRQ)
    );

    // ---------------- clock ----------------
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;
    logic chk_on = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [8:0]  exp_q[$];
    logic        m_ovr = 1'b0, m_par = 1'b0, m_to = 1'b0, m_irq = 1'b0;
    logic [15:0] m_baud = DEF_BT;
    logic [4:0]  m_ctrl = '0;
    logic [31:0] m_rdata = '0;
    int          m_run = 0;

    always @(posedge CLK) begin : model
        logic is_empty, is_full, do_pop, do_flush, quiet, wst;
        int   n_to;
        if (RESET) begin
            exp_q.delete();
            m_ovr = 0; m_par = 0; m_to = 0; m_irq = 0;
            m_baud = DEF_BT; m_ctrl = '0; m_rdata = '0; m_run = 0;
        end else begin
            is_empty = (exp_q.size() == 0);
            is_full  = (exp_q.size() == DEPTH);
            do_pop   = RE && ADDR == REG_DATA && !is_empty;
            do_flush = WE && ADDR == REG_CTRL && WDATA[8];
            wst      = WE && ADDR == REG_STATUS;
            // Timeout: length of the current run of quiet cycles with data waiting.
            quiet    = !is_empty && RX_IDLE && !RX_EN && !do_pop;
            m_run    = quiet ? m_run + 1 : 0;
            n_to     = int'(TB_BITS) * (int'(m_baud) + 1) + 1;
            if (RE) begin
                case (ADDR)
                    REG_DATA:   m_rdata = is_empty ? 32'd0 : {1'b1, 22'd0, exp_q[0]};
                    REG_STATUS: m_rdata = {16'd0, 8'(exp_q.size()), 3'd0, m_to, m_par, m_ovr,
                                           is_full, !is_empty};
                    REG_BAUD:   m_rdata = {16'd0, m_baud};
                    default:    m_rdata = {27'd0, m_ctrl};
                endcase
            end
            m_irq = (m_ctrl[2] && !is_empty) || (m_ctrl[3] && (m_ovr || m_par)) || (m_ctrl[4] && m_to);
            m_ovr = (m_ovr && !(wst && WDATA[2])) || (RX_EN && is_full && !do_pop && !do_flush);
            m_par = (m_par && !(wst && WDATA[3])) || (RX_EN && RX_PERR);
            m_to  = (m_to && !(wst && WDATA[4])) || (TB_BITS != 0 && m_run == n_to);
            if (do_pop) void'(exp_q.pop_front());
            if (do_flush) exp_q.delete();
            else if (RX_EN && (!is_full || do_pop)) exp_q.push_back({RX_PERR, RX_DATA});
            if (WE && ADDR == REG_BAUD) m_baud = WDATA[15:0];
            if (WE && ADDR == REG_CTRL) m_ctrl = WDATA[4:0];
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge CLK) begin
        if (chk_on) begin
            check("rdata", RDATA, m_rdata);
            check("irq", {31'd0, IRQ}, {31'd0, m_irq});
            check("bit_time", {16'd0, BIT_TIME}, {16'd0, m_baud});
            check("parity_cfg", {30'd0, PARITY_ODD, PARITY_EN}, {30'd0, m_ctrl[1:0]});
        end
    end

    // ---------------- drivers ----------------
    task automatic drive(input logic en, input logic [7:0] d, input logic perr, input logic re,
                         input logic we, input logic [1:0] a, input logic [31:0] wd);
        @(negedge CLK);
        RX_EN = en; RX_DATA = d; RX_PERR = perr; RE = re; WE = we; ADDR = a; WDATA = wd;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0);
    endtask

    task automatic push(input logic [7:0] d, input logic perr);
        drive(1'b1, d, perr, 1'b0, 1'b0, 2'd0, 32'd0);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] wd);
        drive(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, a, wd);
    endtask

    task automatic rd_chk(input logic [1:0] a, input logic [31:0] exp, input string name);
        drive(1'b0, 8'd0, 1'b0, 1'b1, 1'b0, a, 32'd0);
        idle(1);
        check(name, RDATA, exp);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        RESET = 1'b1; RX_EN = 0; RX_DATA = 0; RX_PERR = 0; RX_IDLE = 0;
        RE = 0; WE = 0; ADDR = 0; WDATA = 0;
        idle(2);
        push(8'hEE, 1'b1);
        idle(1);
        RESET = 1'b0;
        chk_on = 1'b1;

        check("rst_irq", {31'd0, IRQ}, 32'd0);
        check("rst_bit_time", {16'd0, BIT_TIME}, 32'd434);
        check("rst_parity_en", {31'd0, PARITY_EN}, 32'd0);
        rd_chk(REG_DATA, 32'h0, "rst_data");
        rd_chk(REG_STATUS, 32'h0, "rst_status");
        rd_chk(REG_BAUD, 32'd434, "rst_baud");
        rd_chk(REG_CTRL, 32'h0, "rst_ctrl");

        push(8'h41, 1'b0);
        push(8'h42, 1'b0);
        rd_chk(REG_STATUS, 32'h0000_0201, "two_status");
        rd_chk(REG_DATA, 32'h8000_0041, "two_data0");
        rd_chk(REG_STATUS, 32'h0000_0101, "two_status1");
        rd_chk(REG_DATA, 32'h8000_0042, "two_data1");
        rd_chk(REG_STATUS, 32'h0, "two_status0");
        rd_chk(REG_DATA, 32'h0, "two_empty");

        for (int i = 0; i < 17; i++) push(8'(8'h10 + i), 1'b0);
        rd_chk(REG_STATUS, 32'h0000_1007, "ovr_status");
        wr(REG_STATUS, 32'h4);
        rd_chk(REG_STATUS, 32'h0000_1003, "ovr_cleared");
        for (int i = 0; i < 16; i++) rd_chk(REG_DATA, 32'h8000_0010 + i, "ovr_drain");
        rd_chk(REG_STATUS, 32'h0, "ovr_empty");

        wr(REG_CTRL, 32'h8);
        push(8'h55, 1'b1);
        idle(2);
        check("perr_irq", {31'd0, IRQ}, 32'd1);
        rd_chk(REG_DATA, 32'h8000_0155, "perr_data");
        rd_chk(REG_STATUS, 32'h0000_0008, "perr_status");
        wr(REG_STATUS, 32'h8);
        idle(2);
        check("perr_irq_clr", {31'd0, IRQ}, 32'd0);
        wr(REG_CTRL, 32'h0);

        wr(REG_BAUD, 32'd10);
        RX_IDLE = 1'b1;
        push(8'h77, 1'b0);
        idle(339);
        rd_chk(REG_STATUS, 32'h0000_0101, "to_early");
        idle(14);
        rd_chk(REG_STATUS, 32'h0000_0111, "to_fired");
        rd_chk(REG_DATA, 32'h8000_0077, "to_data");
        wr(REG_STATUS, 32'h10);
        rd_chk(REG_STATUS, 32'h0, "to_cleared");
        push(8'h78, 1'b0);
        idle(300);
        RX_IDLE = 1'b0;
        idle(1);
        RX_IDLE = 1'b1;
        idle(300);
        rd_chk(REG_STATUS, 32'h0000_0101, "to_restart");
        rd_chk(REG_DATA, 32'h8000_0078, "to_restart_data");
        RX_IDLE = 1'b0;

        for (int i = 0; i < 16; i++) push(8'(8'h60 + i), 1'b0);
        drive(1'b1, 8'hAA, 1'b0, 1'b1, 1'b0, REG_DATA, 32'd0);
        idle(1);
        check("full_pushpop", RDATA, 32'h8000_0060);
        rd_chk(REG_STATUS, 32'h0000_1003, "full_status");
        for (int i = 1; i < 16; i++) rd_chk(REG_DATA, 32'h8000_0060 + i, "full_drain");
        rd_chk(REG_DATA, 32'h8000_00AA, "full_last");

        for (int i = 0; i < 3; i++) push(8'(8'h30 + i), 1'b0);
        drive(1'b1, 8'hBB, 1'b0, 1'b0, 1'b1, REG_CTRL, 32'h100);
        idle(1);
        rd_chk(REG_STATUS, 32'h0, "flush_status");
        rd_chk(REG_CTRL, 32'h0, "flush_ctrl");

        // Randomized traffic: segment activity varies so long quiet runs also occur.
        wr(REG_BAUD, 32'd3);
        for (int seg = 0; seg < 8; seg++) begin
            int act;
            act = (seg % 3 == 0) ? 0 : ((seg % 3 == 1) ? 5 : 40);
            for (int c = 0; c < 400; c++) begin
                logic en, perr, re, we;
                logic [1:0] a;
                logic [31:0] wd;
                en   = ($urandom_range(0, 99) < act) || (c == 0);
                perr = ($urandom_range(0, 9) == 0);
                re   = ($urandom_range(0, 99) < act);
                we   = ($urandom_range(0, 399) < act);
                wd   = $urandom;
                if (we) begin
                    a = ($urandom_range(0, 1) == 0) ? REG_STATUS : REG_CTRL;
                    if (a == REG_CTRL) wd[8] = ($urandom_range(0, 7) == 0);
                end else begin
                    a = 2'($urandom_range(0, 3));
                end
                if ($urandom_range(0, 199) == 0) RX_IDLE = ~RX_IDLE;
                if (act == 0) RX_IDLE = 1'b1;
                drive(en, 8'($urandom), perr, re, we, a, wd);
            end
        end

        RESET = 1'b1;
        push(8'($urandom), 1'b1);
        idle(1);
        RESET = 1'b0;
        for (int c = 0; c < 200; c++)
            drive($urandom_range(0, 2) == 0, 8'($urandom), $urandom_range(0, 3) == 0,
                  $urandom_range(0, 3) == 0, 1'b0, 2'($urandom_range(0, 3)), 32'd0);
        rd_chk(REG_BAUD, 32'd434, "post_reset_baud");
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Receive-side controller for the UART receiver datapath. Holds the receiver configuration (bit time, parity mode) and buffers completed bytes in a small FIFO with per-entry parity flags. Tracks overrun, parity and idle-timeout status, and presents everything to the CPU through a 4-word register port with a level interrupt. Sits between the uart_rx instance and the memory-mapped peripheral bus.

Parameters:
DEPTH, 16, FIFO entries; power of 2, range 2..256
DEF_BIT_TIME, 16'd434, reset value of BIT_TIME (50 MHz / 115200)
TIMEOUT_BITS, 8'd32, idle bit-times before the timeout flag sets

Ports:
CLK  in  1  clock
RESET  in  1  synchronous reset, active-high
RX_DATA  in  8  byte from receiver
RX_EN  in  1  one-cycle strobe: RX_DATA/RX_PERR valid
RX_PERR  in  1  parity error for the strobed byte
RX_IDLE  in  1  receiver in ready state
BIT_TIME  out  16  to receiver
PARITY_EN  out  1  to receiver
PARITY_ODD  out  1  to receiver
ADDR  in  2  register select
WE  in  1  write strobe
RE  in  1  read strobe
WDATA  in  32  write data
RDATA  out  32  read data, registered
IRQ  out  1  level interrupt

Behaviour:
- Register map, with addresses as package constants:
  - 0 DATA (RO): [7:0] byte, [8] parity err of that entry, [31] valid. A read pops when non-empty. A read when empty returns 0 and does not pop.
  - 1 STATUS: [0] not_empty, [1] full, [2] overrun (sticky), [3] parity_seen (sticky), [4] timeout (sticky), [15:8] count. Write-1-to-clear on [4:2]. Other bits are RO.
  - 2 BAUD (RW): [15:0] BIT_TIME.
  - 3 CTRL (RW): [0] PARITY_EN, [1] PARITY_ODD, [2] irq_rx_en, [3] irq_err_en, [4] irq_to_en, [8] fifo_flush (self-clearing, reads 0).
- Read latency: RDATA is valid the cycle after RE and holds until the next RE.
- WE and RE in the same cycle: both are performed.
- Reset values: BIT_TIME=DEF_BIT_TIME; CTRL=0; FIFO empty; sticky flags 0; RDATA=0; IRQ=0; timeout counters 0.
- FIFO push on RX_EN:
  - Writes {RX_PERR, RX_DATA}.
  - If full with no pop in the same cycle: byte dropped, overrun set.
  - Full with a pop in the same cycle: push accepted, count unchanged.
  - Empty with push and DATA read in the same cycle: the read returns empty (0); the pushed byte is stored.
- Pointers wrap modulo DEPTH. count ranges 0..DEPTH; count==DEPTH means full. For DEPTH=256 the count field saturates at 255 (full is still indicated by bit [1]).
- parity_seen sets on any push whose RX_PERR=1, even when that push is dropped.
- Flush (CTRL[8] written 1):
  - Empties the FIFO next cycle.
  - Beats a same-cycle push; that byte is lost and overrun is not set.
  - Sticky flags are unchanged.
- Config writes apply immediately to the outputs. Software must only change them while RX_IDLE. The block does not gate writes.
- Timeout FSM:
  - States: TO_OFF, TO_COUNT, TO_FIRED.
  - TO_OFF → TO_COUNT when not_empty & RX_IDLE.
  - In TO_COUNT:
    - A 16-bit prescaler counts 0..BIT_TIME, then wraps.
    - Each wrap increments an 8-bit bit counter.
    - When the bit counter reaches TIMEOUT_BITS: set timeout, go to TO_FIRED.
  - From TO_COUNT or TO_FIRED → TO_OFF, clearing both counters, on any of: push, pop, !RX_IDLE, FIFO empty.
  - TO_FIRED does not re-set timeout after software clears it, until the FSM has left via TO_OFF.
  - TIMEOUT_BITS=0 means timeout is disabled: stay in TO_OFF.
- IRQ, registered (one cycle after the cause): (irq_rx_en & not_empty) | (irq_err_en & (overrun|parity_seen)) | (irq_to_en & timeout).
- RESET mid-frame: everything returns to reset values. A receiver strobe in the reset cycle is ignored.

Decomposition:
- Package uart_pkg holds:
  - register address constants (REG_DATA, REG_STATUS, REG_BAUD, REG_CTRL);
  - STATUS/CTRL bit-index constants;
  - the timeout state enum.
- One sub-module, uart_rx_fifo (parameter DEPTH, width 9). Ports:
  - inputs: CLK, RESET, FLUSH, PUSH, POP, DIN;
  - outputs: DOUT, EMPTY, FULL, COUNT.
  - It implements the full-with-pop and flush-priority rules.

Test Plan:
- Reset, then read all 4 regs → DATA=0, STATUS=0, BAUD=434, CTRL=0; BIT_TIME=434, PARITY_EN=0.
- Strobe bytes 0x41 then 0x42 (RX_PERR=0), then read DATA twice → 0x80000041, then 0x80000042; STATUS count goes 2→1→0; a third read returns 0.
- Push 17 bytes into DEPTH=16 → STATUS full=1, overrun=1, count=16. Write 0x4 to STATUS → overrun clears. Drain 16 reads → first 16 bytes in order.
- Strobe 0x55 with RX_PERR=1 and CTRL=0x8 → DATA read shows bit8=1. parity_seen=1 and IRQ=1 one cycle after the push. Write 0x8 to STATUS → IRQ drops.
- BAUD=10, TIMEOUT_BITS=32, one byte pushed, RX_IDLE held 1 → timeout sets after 32×11 cycles ±2. Toggling RX_IDLE low before that keeps timeout at 0.
- FIFO full, with an RX_EN strobe and a DATA read in the same cycle → no overrun, count stays 16, and the new byte is the last one read out.
